// File: rtl/dsp_logic_pipe_if.sv
// rtl/dsp_logic_pipe_if.sv - ready/valid operand and result bundle for dsp_logic_pipe
interface dsp_logic_pipe_if #(
    parameter int width = 48
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] y;
    logic             y_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, y_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, y_zero
    );
endinterface

// File: rtl/dsp_logic_pipe.sv
// rtl/dsp_logic_pipe.sv - pipelined eight-function bitwise logic unit with registered zero detect
module dsp_logic_pipe #(
    parameter int width   = 48,
    parameter int latency = 2
) (
    input  logic             clock,
    input  logic             reset,
    dsp_logic_pipe_if.slave  bus
);

    if (width < 1 || width > 48) begin : g_bad_width
        $error("dsp_logic_pipe: width must be in 1..48");
    end
    if (latency < 1 || latency > 4) begin : g_bad_latency
        $error("dsp_logic_pipe: latency must be in 1..4");
    end

    logic                            advance;
    logic [width-1:0]                f_y;
    logic                            f_zero;
    logic [latency-1:0]              stage_valid;
    logic [latency-1:0][width-1:0]   stage_y;
    logic [latency-1:0]              stage_zero;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign advance      = bus.out_ready | ~stage_valid[latency-1];
    assign bus.in_ready = advance;

    always_comb begin
        f_y = '0;
        case (bus.op)
            3'd0:    f_y = bus.a & bus.b;
            3'd1:    f_y = bus.a | bus.b;
            3'd2:    f_y = bus.a ^ bus.b;
            3'd3:    f_y = ~(bus.a & bus.b);
            3'd4:    f_y = ~(bus.a | bus.b);
            3'd5:    f_y = ~(bus.a ^ bus.b);
            3'd6:    f_y = bus.a & ~bus.b;
            default: f_y = bus.a | ~bus.b;
        endcase
    end

    assign f_zero = ~|f_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid[0] <= 1'b0;
            stage_y[0]     <= '0;
            stage_zero[0]  <= 1'b0;
        end else if (advance) begin
            stage_valid[0] <= bus.in_valid;
            if (bus.in_valid) begin
                stage_y[0]    <= f_y;
                stage_zero[0] <= f_zero;
            end
        end
    end

    // Bubbles keep their slot but leave the stale payload untouched.
    for (genvar g = 1; g < latency; g++) begin : g_stage
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                stage_valid[g] <= 1'b0;
                stage_y[g]     <= '0;
                stage_zero[g]  <= 1'b0;
            end else if (advance) begin
                stage_valid[g] <= stage_valid[g-1];
                if (stage_valid[g-1]) begin
                    stage_y[g]    <= stage_y[g-1];
                    stage_zero[g] <= stage_zero[g-1];
                end
            end
        end
    end

    assign bus.out_valid = stage_valid[latency-1];
    assign bus.y         = stage_y[latency-1];
    assign bus.y_zero    = stage_zero[latency-1];

endmodule

// File: tb/tb_dsp_logic_pipe.sv
// tb/tb_dsp_logic_pipe.sv - directed-vector bench for dsp_logic_pipe across four configurations
module tb_dsp_logic_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    dsp_logic_pipe_if #(.width(8))  bus8  ();
    dsp_logic_pipe_if #(.width(48)) bus48 ();
    dsp_logic_pipe_if #(.width(8))  busbp ();
    dsp_logic_pipe_if #(.width(1))  bus1  ();

    dsp_logic_pipe #(.width(8),  .latency(2)) u_dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));
    dsp_logic_pipe #(.width(48), .latency(2)) u_dut48 (.clock(clock), .reset(reset), .bus(bus48.slave));
    dsp_logic_pipe #(.width(8),  .latency(3)) u_dutbp (.clock(clock), .reset(reset), .bus(busbp.slave));
    dsp_logic_pipe #(.width(1),  .latency(4)) u_dut1  (.clock(clock), .reset(reset), .bus(bus1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sweep_exp [8] = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'h42, 8'hDB};
    logic [7:0] bp_vals   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bit         bub_v     [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit         bub_b     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit         bub_y     [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  sent;
        int  rcvd;
        int  stall;
        bit  stalled;
        bit  acc;
        bit  xfer;
        int  vi;
        int  vo;

        bus8.in_valid  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b1;
        bus48.in_valid = 1'b0; bus48.op = 3'd0; bus48.a = '0; bus48.b = '0; bus48.out_ready = 1'b1;
        busbp.in_valid = 1'b0; busbp.op = 3'd0; busbp.a = '0; busbp.b = '0; busbp.out_ready = 1'b1;
        bus1.in_valid  = 1'b0; bus1.op  = 3'd0; bus1.a  = '0; bus1.b  = '0; bus1.out_ready  = 1'b1;

        #2;
        check("rst_out_valid", 48'(bus8.out_valid), 48'd0);
        check("rst_y",         48'(bus8.y),         48'd0);
        check("rst_y_zero",    48'(bus8.y_zero),    48'd0);
        check("rst_in_ready",  48'(bus8.in_ready),  48'd1);
        tick;
        tick;
        reset = 1'b0;
        repeat (3) tick;
        check("idle_out_valid", 48'(bus8.out_valid), 48'd0);
        check("idle_y",         48'(bus8.y),         48'd0);

        bus8.a = 8'hCA;
        bus8.b = 8'hAC;
        for (int k = 0; k < 10; k++) begin
            bus8.in_valid = (k < 8);
            bus8.op       = 3'(k);
            if (k < 8) check("sweep_in_ready", 48'(bus8.in_ready), 48'd1);
            tick;
            if (k >= 1 && k <= 8) begin
                check("sweep_out_valid", 48'(bus8.out_valid), 48'd1);
                check("sweep_y",         48'(bus8.y),         48'(sweep_exp[k-1]));
                check("sweep_y_zero",    48'(bus8.y_zero),    48'd0);
            end
        end
        check("sweep_drain", 48'(bus8.out_valid), 48'd0);

        bus48.in_valid = 1'b1;
        bus48.op       = 3'd2;
        bus48.a        = 48'h123456789ABC;
        bus48.b        = 48'h123456789ABC;
        tick;
        bus48.op = 3'd4;
        bus48.a  = '0;
        bus48.b  = '0;
        tick;
        check("zd_valid", 48'(bus48.out_valid), 48'd1);
        check("zd_y",     bus48.y,              48'd0);
        check("zd_zero",  48'(bus48.y_zero),    48'd1);
        bus48.in_valid = 1'b0;
        tick;
        check("nor_y",    bus48.y,              48'hFFFFFFFFFFFF);
        check("nor_zero", 48'(bus48.y_zero),    48'd0);
        bus48.out_ready = 1'b0;
        #1;
        check("nor_stall_in_ready", 48'(bus48.in_ready), 48'd0);
        tick;
        tick;
        check("nor_hold_valid", 48'(bus48.out_valid), 48'd1);
        check("nor_hold_y",     bus48.y,              48'hFFFFFFFFFFFF);

        busbp.op = 3'd0;
        busbp.b  = 8'hFF;
        sent     = 0;
        rcvd     = 0;
        stall    = 0;
        stalled  = 1'b0;
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            if (busbp.out_valid && !stalled) begin
                busbp.out_ready = 1'b0;
                stalled         = 1'b1;
            end
            if (!busbp.out_ready) begin
                #1;
                check("bp_in_ready", 48'(busbp.in_ready),  48'd0);
                check("bp_hold_y",   48'(busbp.y),         48'(bp_vals[0]));
                check("bp_hold_v",   48'(busbp.out_valid), 48'd1);
                stall++;
                if (stall == 3) busbp.out_ready = 1'b1;
            end
            #1;
            busbp.in_valid = (sent < 5);
            busbp.a        = bp_vals[(sent < 5) ? sent : 0];
            acc  = busbp.in_valid && busbp.in_ready;
            xfer = busbp.out_valid && busbp.out_ready;
            if (xfer) begin
                check("bp_order", 48'(busbp.y), 48'(bp_vals[(rcvd < 5) ? rcvd : 0]));
                rcvd++;
            end
            if (acc) sent++;
            tick;
        end
        busbp.in_valid = 1'b0;
        check("bp_sent", 48'(sent), 48'd5);
        check("bp_rcvd", 48'(rcvd), 48'd5);
        repeat (3) tick;
        check("bp_no_extra", 48'(busbp.out_valid), 48'd0);

        bus1.op = 3'd3;
        bus1.a  = 1'b1;
        vi      = 0;
        vo      = 0;
        for (int t = 0; t < 9; t++) begin
            bus1.in_valid = (t < 6) ? bub_v[t] : 1'b0;
            bus1.b        = bub_b[(vi < 4) ? vi : 0];
            if (t < 6 && bub_v[t]) vi++;
            tick;
            if (t >= 3) begin
                check("bub_valid", 48'(bus1.out_valid), 48'(bub_v[t-3]));
                if (bub_v[t-3]) begin
                    check("bub_y", 48'(bus1.y), 48'(bub_y[(vo < 4) ? vo : 0]));
                    vo++;
                end
            end
        end

        bus1.op       = 3'd1;
        bus1.a        = 1'b1;
        bus1.b        = 1'b1;
        bus1.in_valid = 1'b1;
        repeat (3) tick;
        bus1.in_valid = 1'b0;
        check("mf_before_rst", 48'(bus1.out_valid), 48'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_v1",    48'(bus1.out_valid),  48'd0);
        check("async_rst_y1",    48'(bus1.y),          48'd0);
        check("async_rst_v48",   48'(bus48.out_valid), 48'd0);
        check("async_rst_y48",   bus48.y,              48'd0);
        check("async_rst_z48",   48'(bus48.y_zero),    48'd0);
        check("async_rst_rdy48", 48'(bus48.in_ready),  48'd1);
        tick;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            check("mf_no_result", 48'(bus1.out_valid), 48'd0);
        end
        bus1.op       = 3'd3;
        bus1.a        = 1'b1;
        bus1.b        = 1'b0;
        bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick;
            check("mf_new_valid", 48'(bus1.out_valid), 48'(c == 3));
            if (c == 3) check("mf_new_y", 48'(bus1.y), 48'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
